// File: rtl/mem_miss_ctrl_pkg.sv
// Shared types and constants for the miss-service controller.
package mips_pkg;

  localparam int WORD_W             = 16;
  localparam int DEFAULT_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DFILL = 2'd1,
    IFILL = 2'd2,
    DONE  = 2'd3
  } miss_state_t;

endpackage

// File: rtl/mem_miss_ctrl_if.sv
// Bundle of cache-miss, memory-port and fill signals around the miss controller.
// The master side is the controller; the slave side is caches plus memory.
interface mem_miss_if
  import mips_pkg::*;
#(
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int ADDR_W     = 16
);

  logic                          imiss;
  logic [ADDR_W-1:0]             imiss_addr;
  logic                          dmiss;
  logic [ADDR_W-1:0]             dmiss_addr;
  logic                          mem_ack;
  logic [WORD_W-1:0]             mem_rdata;
  logic                          mem_req;
  logic [ADDR_W-1:0]             mem_addr;
  logic                          ifill_we;
  logic                          dfill_we;
  logic [$clog2(LINE_WORDS)-1:0] fill_idx;
  logic [WORD_W-1:0]             fill_data;
  logic                          fill_done;
  logic                          hit;

  modport master (
    input  imiss, imiss_addr, dmiss, dmiss_addr, mem_ack, mem_rdata,
    output mem_req, mem_addr, ifill_we, dfill_we, fill_idx, fill_data, fill_done, hit
  );

  modport slave (
    output imiss, imiss_addr, dmiss, dmiss_addr, mem_ack, mem_rdata,
    input  mem_req, mem_addr, ifill_we, dfill_we, fill_idx, fill_data, fill_done, hit
  );

endinterface

// File: rtl/mem_miss_ctrl_line_word_counter.sv
// Loadable word counter within a cache line; the terminal-count flag marks
// the last word so the controller knows when the line is complete.
module line_word_counter #(
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_i,
  input  logic                          inc_i,
  output logic [$clog2(LINE_WORDS)-1:0] cnt_o,
  output logic                          tc_o
);

  localparam int IDX_W = $clog2(LINE_WORDS);

  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] cnt_d;

  // Next count: load clears to word 0, increment wraps naturally at the line end.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_miss_ctrl.sv
// Miss-service controller: arbitrates I/D line refills onto the single memory
// read port and holds the pipeline frozen (hit low) while any miss is open.
module mem_miss_ctrl
  import mips_pkg::*;
#(
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int ADDR_W     = 16
) (
  input logic       clk,
  input logic       rst_n,
  mem_miss_if.master bus
);

  localparam int                IDX_W       = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_WORDS - 1);

  miss_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] miss_base;
  logic              cnt_load;
  logic              ack_in_fill;
  logic              cnt_tc;
  logic [IDX_W-1:0]  cnt;

  // The D-miss wins arbitration because its instruction is older.
  assign miss_base   = (bus.dmiss ? bus.dmiss_addr : bus.imiss_addr) & ~OFFSET_MASK;
  assign ack_in_fill = ((state_q == DFILL) || (state_q == IFILL)) && bus.mem_ack;

  line_word_counter #(
    .LINE_WORDS(LINE_WORDS)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .inc_i  (ack_in_fill),
    .cnt_o  (cnt),
    .tc_o   (cnt_tc)
  );

  // Next-state and registered request/address computation.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    cnt_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dmiss || bus.imiss) begin
          state_d    = bus.dmiss ? DFILL : IFILL;
          base_d     = miss_base;
          mem_addr_d = miss_base;
          mem_req_d  = 1'b1;
          cnt_load   = 1'b1;
        end
      end
      DFILL, IFILL: begin
        if (bus.mem_ack) begin
          if (cnt_tc) begin
            state_d   = DONE;
            mem_req_d = 1'b0;
          end else begin
            mem_addr_d = base_q + ADDR_W'(cnt) + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, line base and memory request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.dfill_we  = (state_q == DFILL) && bus.mem_ack;
  assign bus.ifill_we  = (state_q == IFILL) && bus.mem_ack;
  assign bus.fill_idx  = cnt;
  assign bus.fill_data = bus.mem_rdata;
  assign bus.fill_done = (state_q == DONE);
  assign bus.hit       = (state_q == IDLE) && !bus.imiss && !bus.dmiss;

endmodule

// File: doc/mem_miss_ctrl.md
# mem_miss_ctrl

Miss-service controller for the 16-bit pipeline. It shares the single main-memory read port between instruction-cache and data-cache line refills. It drives the global `hit` advance-enable that every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) samples on the falling edge of `clk`. While any miss is pending or being serviced, `hit` is held low so the whole pipeline freezes. When the refill completes, `hit` is released.

## Interface
Parameters:
- `LINE_WORDS`, default 4: words per cache line. Must be a power of two, from 2 to 16.
- `ADDR_W`, default 16: word-address width.

Ports:
- `clk`, in, 1: the single clock. The FSM updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `imiss`, in, 1: instruction-cache miss, level. Held until that line is filled.
- `imiss_addr`, in, ADDR_W: missing instruction address.
- `dmiss`, in, 1: data-cache miss, level. Held until that line is filled.
- `dmiss_addr`, in, ADDR_W: missing data address.
- `mem_ack`, in, 1: main memory has returned one word this cycle.
- `mem_rdata`, in, 16: returned word, valid when `mem_ack` is 1.
- `mem_req`, out, 1: read request to main memory.
- `mem_addr`, out, ADDR_W: word address of the current request.
- `ifill_we`, out, 1: write `fill_data` into the I-cache at `fill_idx`.
- `dfill_we`, out, 1: write `fill_data` into the D-cache at `fill_idx`.
- `fill_idx`, out, log2(LINE_WORDS): word index within the line.
- `fill_data`, out, 16: `mem_rdata` passed through combinationally.
- `fill_done`, out, 1: one-cycle pulse. The last word of the line has been written.
- `hit`, out, 1: pipeline advance enable.

## Operation
- States: `IDLE`, `DFILL`, `IFILL`, `DONE`.
- Transitions out of `IDLE`:
  - `dmiss`=1 → `DFILL`. `dmiss` has priority because its instruction is older.
  - else `imiss`=1 → `IFILL`.
  - else stay in `IDLE`.
- On entry to a fill state:
  - Latch the line base: the miss address with its low log2(LINE_WORDS) bits cleared.
  - Set the word counter `cnt` to 0.
- In `DFILL`/`IFILL`:
  - `mem_req`=1 and `mem_addr` = base + `cnt`.
  - On `mem_ack`: assert the matching `*fill_we` combinationally and increment `cnt`.
  - When `cnt` = LINE_WORDS-1 and `mem_ack`=1, go to `DONE`.
  - `mem_ack` while in `IDLE` or `DONE` is ignored; no write-enable is asserted.
- In `DONE`:
  - `fill_done`=1 for exactly one cycle, then return to `IDLE`.
  - Re-arbitration happens in `IDLE` on the next cycle. If both misses were pending, the I-miss is serviced next, with no further idle gap.
- `hit` = (state==`IDLE`) & ~`imiss` & ~`dmiss`. It is combinational, so it is stable well before the falling edge at which the pipeline registers sample it.
- Address arithmetic: base + `cnt` never carries out of the line, because the base is line-aligned. `mem_addr` wraps modulo 2^ADDR_W only at the top of memory, and no wrap logic is required.
- The latched base and the requester are frozen for the whole fill. Changes on `*miss_addr` or deassertion of a miss mid-fill do not abort the fill; the line is completed regardless.

## Timing
- Reset values: state=`IDLE`, `cnt`=0, base=0, `mem_req`=0, `mem_addr`=0, `ifill_we`=`dfill_we`=0, `fill_done`=0, `fill_idx`=0. `hit` follows its equation; with no misses asserted it is 1.
- Reset asserted mid-fill: everything returns to reset values immediately. The partially filled line is not marked valid because `fill_done` never pulsed. After release, a still-asserted miss restarts at word 0.
- Latency:
  - Miss asserted in cycle N → `mem_req` in cycle N+1.
  - With single-cycle `mem_ack`, LINE_WORDS request cycles follow, then `DONE`.
  - `hit` returns to 1 in the cycle after `DONE`, provided the cache has dropped its miss. The cache drops the miss on `fill_done`.
- `mem_req` and `mem_addr` are registered outputs and do not glitch. `mem_addr` changes only in the cycle after an `mem_ack`.
- The memory may hold `mem_ack` low for any number of cycles. The request stays asserted and the address stays stable until `mem_ack`.

## Structure
- Shared package (`mips_pkg`) holds:
  - The state enum `miss_state_t` (`IDLE`, `DFILL`, `IFILL`, `DONE`).
  - The constants `WORD_W`=16 and default `LINE_WORDS`=4.
- One sub-module is natural: `line_word_counter`. It is a loadable up-counter with a terminal-count flag, used for `cnt` and `fill_idx`.
- Everything else is a single FSM plus output decode.

## Test plan
- Single D-miss: `dmiss`=1 at `dmiss_addr`=0x0123, `mem_ack` every cycle → `mem_addr` = 0x0120, 0x0121, 0x0122, 0x0123; 4 `dfill_we` pulses with `fill_idx` 0..3; one `fill_done`; `hit`=0 throughout, then 1.
- Simultaneous misses: `imiss`@0x0040 and `dmiss`@0x0805 in the same cycle → the D line (0x0804..0x0807) is filled first, then the I line (0x0040..0x0043); `ifill_we` never asserts during the D fill.
- Slow memory: `mem_ack` once every 3 cycles → `mem_req` stays 1 and `mem_addr` holds each word for 3 cycles; total fill takes 12 request cycles.
- Reset mid-fill: `rst_n` pulled low after word 2 → outputs go to reset values immediately; after release with `imiss` still set, the fill restarts at `fill_idx`=0.
- Stray ack: `mem_ack`=1 while in `IDLE` → no fill write-enable asserts and `hit` stays 1.
- `LINE_WORDS`=8 build: miss at 0xFFFD → addresses 0xFFF8..0xFFFF and exactly 8 writes.
